sync_fwft_fifo: RTL and testbench

SYNC_FWFT_FIFO -- requirements
Module: sync_fwft_fifo

---
 rtl/sync_fwft_fifo_pkg.sv | 15 +
 rtl/fifo_ram.sv | 27 ++
 rtl/sync_fwft_fifo.sv | 115 +++++++++++
 tb/tb_sync_fwft_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fwft_fifo_pkg.sv
// Shared helpers for sync_fwft_fifo: counter width and default programmable-full level.
package sync_fwft_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int default_prog_full_thresh(input int addr_bits);
    return (1 << addr_bits) - 4;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
module fifo_ram #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fwft_fifo.sv
// Single-clock FIFO with selectable first-word-fall-through or standard read mode.
module sync_fwft_fifo
  import sync_fwft_fifo_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int ADDR_BITS        = 4,
  parameter int FWFT             = 1,
  parameter int PROG_FULL_THRESH = default_prog_full_thresh(ADDR_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     din,
  output logic                 full,
  output logic                 prog_full,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(PROG_FULL_THRESH);

  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_q, count_nxt, ram_cnt;
  logic                 full_q, prog_full_q, empty_q, empty_nxt;
  logic                 overflow_q, underflow_q;
  logic                 wr_acc, rd_acc, ram_rd, load_p2;
  logic [WIDTH-1:0]     q_p1, dout_p2;
  logic                 vld_p1, vld_p2, vld_p1_nxt, vld_p2_nxt;

  // ram_cnt counts words still in memory; staged words are counted only in count_q
  always_comb begin
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q;
    load_p2    = 1'b0;
    ram_rd     = 1'b0;
    vld_p1_nxt = vld_p1;
    vld_p2_nxt = 1'b0;
    count_nxt  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    if (FWFT != 0) begin
      load_p2    = vld_p1 && (!vld_p2 || rd_acc);
      ram_rd     = (ram_cnt != '0) && (!vld_p1 || load_p2);
      vld_p1_nxt = ram_rd ? 1'b1 : (load_p2 ? 1'b0 : vld_p1);
      vld_p2_nxt = load_p2 ? 1'b1 : (rd_acc ? 1'b0 : vld_p2);
      empty_nxt  = !vld_p2_nxt;
    end else begin
      ram_rd     = rd_acc;
      vld_p1_nxt = vld_p1 || ram_rd;
      empty_nxt  = (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      ram_cnt     <= '0;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (ram_rd) rd_ptr <= rd_ptr + ADDR_BITS'(1);
      count_q     <= count_nxt;
      ram_cnt     <= ram_cnt + CNT_W'(wr_acc) - CNT_W'(ram_rd);
      full_q      <= (count_nxt == DEPTH_C);
      prog_full_q <= (count_nxt >= THRESH_C);
      empty_q     <= empty_nxt;
      overflow_q  <= wr_en && full_q;
      underflow_q <= rd_en && empty_q;
      vld_p1      <= vld_p1_nxt;
      vld_p2      <= vld_p2_nxt;
    end
  end

  // stage p1: memory read register
  fifo_ram #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (ram_rd && !rst),
    .raddr (rd_ptr),
    .rdata (q_p1)
  );

  // stage p2: fall-through output register, cleared so dout reads zero after reset
  always_ff @(posedge clk) begin
    if (rst)          dout_p2 <= '0;
    else if (load_p2) dout_p2 <= q_p1;
  end

  assign dout      = (FWFT != 0) ? dout_p2 : (vld_p1 ? q_p1 : '0);
  assign full      = full_q;
  assign prog_full = prog_full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Directed bench for sync_fwft_fifo: FWFT instance (a) and standard-mode instance (b).
module tb_sync_fwft_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_a, rd_en_a, wr_en_b, rd_en_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic       full_a, prog_full_a, empty_a, overflow_a, underflow_a;
  logic       full_b, prog_full_b, empty_b, overflow_b, underflow_b;
  logic [4:0] count_a, count_b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  sync_fwft_fifo #(.WIDTH(8), .ADDR_BITS(4), .FWFT(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .din(din_a), .full(full_a),
    .prog_full(prog_full_a), .rd_en(rd_en_a), .dout(dout_a), .empty(empty_a),
    .count(count_a), .overflow(overflow_a), .underflow(underflow_a)
  );

  sync_fwft_fifo #(.WIDTH(8), .ADDR_BITS(4), .FWFT(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .din(din_b), .full(full_b),
    .prog_full(prog_full_b), .rd_en(rd_en_b), .dout(dout_b), .empty(empty_b),
    .count(count_b), .overflow(overflow_b), .underflow(underflow_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full_a); end
    checks++; if (prog_full_a !== 1'b0) begin errors++; $display("FAIL reset_prog_full got=%b want=0", prog_full_a); end
    checks++; if (count_a !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count_a); end
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", dout_a); end
    checks++; if (overflow_a !== 1'b0 || underflow_a !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b want=00", overflow_a, underflow_a); end
    checks++; if (empty_b !== 1'b1 || dout_b !== 8'h00) begin errors++; $display("FAIL reset_std got empty=%b dout=%h want 1/00", empty_b, dout_b); end
  endtask

  task automatic test_first_word();
    wr_en_a = 1'b1; din_a = 8'hA5;
    step();
    wr_en_a = 1'b0;
    checks++; if (count_a !== 5'd1) begin errors++; $display("FAIL fw_count_n got=%0d want=1", count_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL fw_empty_n got=%b want=1", empty_a); end
    step();
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL fw_empty_n1 got=%b want=1", empty_a); end
    step();
    checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL fw_empty_n2 got=%b want=0", empty_a); end
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL fw_dout got=%h want=a5", dout_a); end
    rd_en_a = 1'b1;
    step();
    rd_en_a = 1'b0;
    checks++; if (empty_a !== 1'b1 || count_a !== 5'd0) begin errors++; $display("FAIL fw_pop got empty=%b count=%0d want 1/0", empty_a, count_a); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_en_a = 1'b1; din_a = 8'(i);
      step();
      checks++; if (prog_full_a !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_prog_full n=%0d got=%b want=%b", i + 1, prog_full_a, (i + 1 >= 12)); end
    end
    checks++; if (full_a !== 1'b1 || count_a !== 5'd16) begin errors++; $display("FAIL fill_full got full=%b count=%0d want 1/16", full_a, count_a); end
    din_a = 8'hFF;
    step();
    wr_en_a = 1'b0;
    checks++; if (overflow_a !== 1'b1 || count_a !== 5'd16) begin errors++; $display("FAIL ovf_pulse got ovf=%b count=%0d want 1/16", overflow_a, count_a); end
    step();
    checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", overflow_a); end
  endtask

  task automatic test_full_wr_rd();
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL full_head got=%h want=00", dout_a); end
    wr_en_a = 1'b1; rd_en_a = 1'b1; din_a = 8'hEE;
    step();
    wr_en_a = 1'b0;
    checks++; if (overflow_a !== 1'b1 || count_a !== 5'd15 || full_a !== 1'b0) begin errors++; $display("FAIL full_wr_rd got ovf=%b count=%0d full=%b want 1/15/0", overflow_a, count_a, full_a); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (dout_a !== 8'(i) || empty_a !== 1'b0) begin errors++; $display("FAIL drain i=%0d got dout=%h empty=%b want %h/0", i, dout_a, empty_a, 8'(i)); end
      step();
    end
    rd_en_a = 1'b0;
    checks++; if (empty_a !== 1'b1 || count_a !== 5'd0) begin errors++; $display("FAIL drain_end got empty=%b count=%0d want 1/0", empty_a, count_a); end
  endtask

  task automatic test_underflow();
    rd_en_a = 1'b1;
    step();
    rd_en_a = 1'b0;
    checks++; if (underflow_a !== 1'b1 || count_a !== 5'd0) begin errors++; $display("FAIL udf_pulse got udf=%b count=%0d want 1/0", underflow_a, count_a); end
    step();
    checks++; if (underflow_a !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b want=0", underflow_a); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr_en_a = 1'b1; din_a = 8'(i);
      step();
    end
    wr_en_a = 1'b0;
    step();
    step();
    for (int k = 0; k < 40; k++) begin
      checks++; if (dout_a !== 8'(k) || count_a !== 5'd8 || empty_a !== 1'b0) begin errors++; $display("FAIL b2b k=%0d got dout=%h count=%0d empty=%b want %h/8/0", k, dout_a, count_a, empty_a, 8'(k)); end
      wr_en_a = 1'b1; rd_en_a = 1'b1; din_a = 8'(8 + k);
      step();
    end
    wr_en_a = 1'b0;
    for (int k = 40; k < 48; k++) begin
      checks++; if (dout_a !== 8'(k)) begin errors++; $display("FAIL b2b_drain k=%0d got=%h want=%h", k, dout_a, 8'(k)); end
      step();
    end
    rd_en_a = 1'b0;
    checks++; if (empty_a !== 1'b1 || count_a !== 5'd0) begin errors++; $display("FAIL b2b_end got empty=%b count=%0d want 1/0", empty_a, count_a); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      wr_en_a = 1'b1; din_a = 8'(8'h10 + i);
      step();
    end
    rst = 1'b1; din_a = 8'h99;
    step();
    rst = 1'b0; wr_en_a = 1'b0;
    checks++; if (empty_a !== 1'b1 || count_a !== 5'd0 || dout_a !== 8'h00) begin errors++; $display("FAIL rst_mid got empty=%b count=%0d dout=%h want 1/0/00", empty_a, count_a, dout_a); end
    step();
    checks++; if (count_a !== 5'd0) begin errors++; $display("FAIL rst_mid_ignore got count=%0d want=0", count_a); end
    wr_en_a = 1'b1; din_a = 8'h77;
    step();
    wr_en_a = 1'b0;
    step();
    step();
    checks++; if (empty_a !== 1'b0 || dout_a !== 8'h77 || count_a !== 5'd1) begin errors++; $display("FAIL rst_first got empty=%b dout=%h count=%0d want 0/77/1", empty_a, dout_a, count_a); end
    rd_en_a = 1'b1;
    step();
    rd_en_a = 1'b0;
  endtask

  task automatic test_std_mode();
    wr_en_b = 1'b1; din_b = 8'h3C;
    step();
    wr_en_b = 1'b0;
    checks++; if (empty_b !== 1'b0 || count_b !== 5'd1 || dout_b !== 8'h00) begin errors++; $display("FAIL std_write got empty=%b count=%0d dout=%h want 0/1/00", empty_b, count_b, dout_b); end
    rd_en_b = 1'b1;
    step();
    rd_en_b = 1'b0;
    checks++; if (dout_b !== 8'h3C || empty_b !== 1'b1 || count_b !== 5'd0) begin errors++; $display("FAIL std_read got dout=%h empty=%b count=%0d want 3c/1/0", dout_b, empty_b, count_b); end
    step();
    checks++; if (dout_b !== 8'h3C) begin errors++; $display("FAIL std_hold got=%h want=3c", dout_b); end
    wr_en_b = 1'b1; din_b = 8'h11;
    step();
    din_b = 8'h22;
    step();
    wr_en_b = 1'b0; rd_en_b = 1'b1;
    step();
    rd_en_b = 1'b0;
    checks++; if (dout_b !== 8'h11 || count_b !== 5'd1) begin errors++; $display("FAIL std_seq1 got dout=%h count=%0d want 11/1", dout_b, count_b); end
    rd_en_b = 1'b1;
    step();
    checks++; if (dout_b !== 8'h22 || empty_b !== 1'b1) begin errors++; $display("FAIL std_seq2 got dout=%h empty=%b want 22/1", dout_b, empty_b); end
    step();
    rd_en_b = 1'b0;
    checks++; if (underflow_b !== 1'b1 || dout_b !== 8'h22) begin errors++; $display("FAIL std_udf got udf=%b dout=%h want 1/22", underflow_b, dout_b); end
  endtask

  initial begin
    rst = 1'b1;
    wr_en_a = 1'b0; rd_en_a = 1'b0; din_a = 8'h00;
    wr_en_b = 1'b0; rd_en_b = 1'b0; din_b = 8'h00;
    #1;
    test_reset();
    test_first_word();
    test_fill_overflow();
    test_full_wr_rd();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_std_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
